pcie_us_msi_mf: RTL and testbench
=================================

# pcie_us_msi_mf

Multi-function MSI request controller for the UltraScale+ PCIe hard block's `cfg_interrupt_msi_*` interface. It sits between the core's interrupt sources and the PCIe IP. It collects edge-triggered requests for up to 4 physical functions and tracks them as pending vectors. It reads back per-function mask registers, arbitrates requests across functions and issues them one at a time, retrying any request the IP rejects. It also reports pending status back to the IP.

## Interface
- `FUNC_COUNT`, 4: physical functions served, 1..4.
- `MSI_COUNT`, 32: vectors per function, 1..32.
- `RETRY_DELAY`, 16: back-off cycles after `fail`, 1..255.

Clock and reset are fixed: one clock, `rst` synchronous active-high.

- `clk`  in  1  PCIe user clock.
- `rst`  in  1  synchronous active-high reset.
- `msi_irq`  in  FUNC_COUNT*MSI_COUNT  request lines; bit f*MSI_COUNT+v is function f, vector v; rising-edge sensitive.
- `cfg_interrupt_msi_enable`  in  4  MSI enable, one bit per function.
- `cfg_interrupt_msi_mmenable`  in  12  multiple-message enable, 3 bits per function.
- `cfg_interrupt_msi_mask_update`  in  1  a mask register changed.
- `cfg_interrupt_msi_data`  in  32  mask data for `select`.
- `cfg_interrupt_msi_select`  out  4  function whose mask is read.
- `cfg_interrupt_msi_int`  out  32  one-hot vector request, single-cycle.
- `cfg_interrupt_msi_function_number`  out  4  function of the request.
- `cfg_interrupt_msi_sent`  in  1  request accepted.
- `cfg_interrupt_msi_fail`  in  1  request rejected.
- `cfg_interrupt_msi_pending_status`  out  32  pending word.
- `cfg_interrupt_msi_pending_status_data_enable`  out  1  pending word valid, single-cycle.
- `cfg_interrupt_msi_pending_status_function_num`  out  4  function of the pending word.
- `cfg_interrupt_msi_attr`  out  3  constant 0.
- `cfg_interrupt_msi_tph_present`  out  1  constant 0.
- `cfg_interrupt_msi_tph_type`  out  2  constant 0.
- `cfg_interrupt_msi_tph_st_tag`  out  9  constant 0.
- `stat_sent`  out  1  pulses when a request is accepted.
- `stat_fail`  out  1  pulses when a request is rejected.
- `stat_drop`  out  1  pulses when an edge arrives on an unallocated vector.

## Operation
**Edge capture**
- `msi_irq` is registered.
- A rising edge on an allocated vector sets its pending bit.
- Allocated vectors for function f are v < min(MSI_COUNT, 2^mmenable[f]).
- An edge on an unallocated vector is discarded and pulses `stat_drop` once per cycle.

**Eligibility**
- A vector is eligible when it is pending, not masked, and `enable[f]`=1.
- While a function is disabled its pending bits are held, not cleared.

**Mask shadow**
- Reset value: all-ones (everything masked).

**FSM**
- States: MASK_SEL, MASK_CAP, IDLE, ISSUE, WAIT, BACKOFF.
- MASK_SEL: drive `select`=f.
- MASK_CAP: capture `msi_data` into `mask[f]`. If f is the last function go to IDLE, otherwise go to MASK_SEL with f+1.
- After reset the FSM enters MASK_SEL with f=0.
- A `mask_update` seen in any state sets a flag. IDLE services the flag first by re-entering MASK_SEL with f=0.
- IDLE: round-robin over functions, starting after the last function granted. Within a function the lowest eligible vector wins. On a winner, go to ISSUE.
- ISSUE: `int` is one-hot for exactly one cycle with `function_number`, then go to WAIT.
- WAIT on `sent`: clear the pending bit, pulse `stat_sent`, go to IDLE. If a new edge for the same vector arrived after ISSUE, the bit stays set.
- WAIT on `fail`: bit stays pending, pulse `stat_fail`, go to BACKOFF.
- BACKOFF: load a counter with RETRY_DELAY, count to 0, then go to IDLE.
- `sent` and `fail` asserted together are treated as `fail`.

**Pending report**
- Each cycle, take the lowest function whose pending word differs from the last word reported for it.
- Drive that function's word on `pending_status` with `data_enable`=1 and `function_num`=f, then update the last-reported copy.
- Reporting runs independently of the FSM.

## Timing
- Reset values: all outputs 0. FSM state MASK_SEL. Pending bits, last-reported copies, retry counter and mask_update flag are 0. Masks are all-ones.
- Latency: edge sampled at cycle N, pending at N+1, `int` at N+2 if the FSM is idle.
- Issue rate: at most one request in flight. Minimum 3 cycles per request (IDLE, ISSUE, WAIT with `sent` the same cycle).
- Mask read: 2*FUNC_COUNT cycles.
- `rst` mid-request drops the request silently. The IP's later `sent` or `fail` is ignored outside WAIT.

## Structure
- Shared package `pcie_us_msi_pkg` holds:
  - FSM state enum;
  - `MSI_VEC_MAX`=32, `MSI_FUNC_MAX`=4;
  - function `msi_alloc_mask(mmenable)` returning the 32-bit allocated-vector mask.
- One sub-module, `pcie_us_msi_prio_enc`, a parametrised lowest-set-bit encoder returning a valid flag and an index. It is used for vector selection and for pending-report selection.

## Test plan
- Reset, then function 0 mask read returns 0. Edge on f0 v3 with enable=1 and mmenable=5 gives `int`=0x8, `function_number`=0 at N+2. `sent` on the next cycle clears the bit, then a pending-status update with word 0 follows.
- mmenable[1]=2 (4 vectors) and an edge on f1 v9: no `int`, `stat_drop`=1.
- After a mask_update, function 2 mask reads 0x1 and an edge arrives on f2 v0. The request is held. Mask then reads 0, and `int`=0x1 is issued.
- `fail` on the first attempt gives `stat_fail`, no new `int` for 16 cycles, then reissue. `sent` then clears the bit.
- Edges on f0 v1, f1 v0 and f3 v2 in the same cycle issue in order f0, f1, f3. The next round starts after f3.
- A second edge on the same vector during WAIT, followed by `sent`, leaves the bit pending and causes a second issue.

Source files
------------

// File: rtl/pcie_us_msi_pkg.sv
// Shared types and helpers for the multi-function MSI request controller.
package pcie_us_msi_pkg;

  localparam int MSI_VEC_MAX  = 32;
  localparam int MSI_FUNC_MAX = 4;

  typedef enum logic [2:0] {
    ST_MASK_SEL,
    ST_MASK_CAP,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_BACKOFF
  } msi_state_e;

  // 2^mmenable vectors granted; encodings >= 5 saturate at the full 32.
  function automatic logic [MSI_VEC_MAX-1:0] msi_alloc_mask(input logic [2:0] mmenable);
    if (mmenable >= 3'd5) return '1;
    return (32'h1 << (32'h1 << mmenable)) - 32'h1;
  endfunction

endpackage

// File: rtl/pcie_us_msi_prio_enc.sv
// Lowest-set-bit encoder: valid flag plus index of the lowest request.
module pcie_us_msi_prio_enc #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic [WIDTH-1:0] req,
  output logic             vld,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    vld = |req;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (req[i]) idx = IDX_W'(i);
  end

endmodule

// File: rtl/pcie_us_msi_mf.sv
// Multi-function MSI requester: edge capture, mask shadow, round-robin issue
// with retry back-off, and pending-status reporting.
module pcie_us_msi_mf
  import pcie_us_msi_pkg::*;
#(
  parameter int FUNC_COUNT  = 4,
  parameter int MSI_COUNT   = 32,
  parameter int RETRY_DELAY = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [FUNC_COUNT*MSI_COUNT-1:0] msi_irq,
  input  logic [3:0]                      cfg_interrupt_msi_enable,
  input  logic [11:0]                     cfg_interrupt_msi_mmenable,
  input  logic                            cfg_interrupt_msi_mask_update,
  input  logic [31:0]                     cfg_interrupt_msi_data,
  output logic [3:0]                      cfg_interrupt_msi_select,
  output logic [31:0]                     cfg_interrupt_msi_int,
  output logic [3:0]                      cfg_interrupt_msi_function_number,
  input  logic                            cfg_interrupt_msi_sent,
  input  logic                            cfg_interrupt_msi_fail,
  output logic [31:0]                     cfg_interrupt_msi_pending_status,
  output logic                            cfg_interrupt_msi_pending_status_data_enable,
  output logic [3:0]                      cfg_interrupt_msi_pending_status_function_num,
  output logic [2:0]                      cfg_interrupt_msi_attr,
  output logic                            cfg_interrupt_msi_tph_present,
  output logic [1:0]                      cfg_interrupt_msi_tph_type,
  output logic [8:0]                      cfg_interrupt_msi_tph_st_tag,
  output logic                            stat_sent,
  output logic                            stat_fail,
  output logic                            stat_drop
);

  localparam logic [1:0] LAST_F = 2'(FUNC_COUNT - 1);

  typedef logic [FUNC_COUNT-1:0][MSI_COUNT-1:0] vec_arr_t;

  vec_arr_t irq_d, irq_q, edge_v, set_v, clr_v, pend, rep, mask, alloc, elig;
  logic [MSI_VEC_MAX-1:0]       am;
  logic [FUNC_COUNT-1:0]        f_vld, diff;
  logic [FUNC_COUNT-1:0][4:0]   f_idx;
  logic                         rr_vld, rep_vld, rearm, upd;
  logic [1:0]                   rr_f, rep_f, last_f, fidx, cur_f, cand;
  logic [4:0]                   cur_v;
  logic [7:0]                   cnt;
  msi_state_e                   state;

  assign irq_d  = msi_irq;
  assign edge_v = irq_d & ~irq_q;
  assign set_v  = edge_v & alloc;

  always_comb begin
    am    = '0;
    alloc = '0;
    elig  = '0;
    diff  = '0;
    for (int f = 0; f < FUNC_COUNT; f++) begin
      am       = msi_alloc_mask(cfg_interrupt_msi_mmenable[3*f +: 3]);
      alloc[f] = am[MSI_COUNT-1:0];
      elig[f]  = pend[f] & ~mask[f] & {MSI_COUNT{cfg_interrupt_msi_enable[f]}};
      diff[f]  = |(pend[f] ^ rep[f]);
    end
  end

  for (genvar f = 0; f < FUNC_COUNT; f++) begin : g_vec
    pcie_us_msi_prio_enc #(.WIDTH(MSI_COUNT), .IDX_W(5)) u_vec (
      .req (elig[f]),
      .vld (f_vld[f]),
      .idx (f_idx[f])
    );
  end

  pcie_us_msi_prio_enc #(.WIDTH(FUNC_COUNT), .IDX_W(2)) u_rep (
    .req (diff),
    .vld (rep_vld),
    .idx (rep_f)
  );

  // Round-robin: scan downward so the function closest after last_f wins.
  always_comb begin
    rr_vld = 1'b0;
    rr_f   = '0;
    cand   = '0;
    for (int i = FUNC_COUNT; i >= 1; i--) begin
      cand = 2'((int'(last_f) + i) % FUNC_COUNT);
      if (f_vld[cand]) begin
        rr_vld = 1'b1;
        rr_f   = cand;
      end
    end
  end

  // A re-edge on the in-flight vector keeps it pending past the sent.
  always_comb begin
    clr_v = '0;
    if (state == ST_WAIT && cfg_interrupt_msi_sent && !cfg_interrupt_msi_fail && !rearm)
      clr_v[cur_f][cur_v] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q     <= '0;
      pend      <= '0;
      stat_drop <= 1'b0;
    end else begin
      irq_q     <= irq_d;
      pend      <= (pend & ~clr_v) | set_v;
      stat_drop <= |(edge_v & ~alloc);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                             <= ST_MASK_SEL;
      fidx                              <= '0;
      mask                              <= '1;
      upd                               <= 1'b0;
      cnt                               <= '0;
      cur_f                             <= '0;
      cur_v                             <= '0;
      last_f                            <= LAST_F;
      rearm                             <= 1'b0;
      cfg_interrupt_msi_select          <= '0;
      cfg_interrupt_msi_int             <= '0;
      cfg_interrupt_msi_function_number <= '0;
      stat_sent                         <= 1'b0;
      stat_fail                         <= 1'b0;
    end else begin
      cfg_interrupt_msi_int <= '0;
      stat_sent             <= 1'b0;
      stat_fail             <= 1'b0;
      if (cfg_interrupt_msi_mask_update) upd <= 1'b1;
      if ((state == ST_ISSUE || state == ST_WAIT) && set_v[cur_f][cur_v]) rearm <= 1'b1;
      case (state)
        ST_MASK_SEL: begin
          cfg_interrupt_msi_select <= {2'b00, fidx};
          state                    <= ST_MASK_CAP;
        end
        ST_MASK_CAP: begin
          mask[fidx] <= cfg_interrupt_msi_data[MSI_COUNT-1:0];
          if (fidx == LAST_F) state <= ST_IDLE;
          else begin
            fidx  <= fidx + 2'd1;
            state <= ST_MASK_SEL;
          end
        end
        ST_IDLE: begin
          if (upd) begin
            upd   <= cfg_interrupt_msi_mask_update;
            fidx  <= '0;
            state <= ST_MASK_SEL;
          end else if (rr_vld) begin
            cur_f                             <= rr_f;
            cur_v                             <= f_idx[rr_f];
            last_f                            <= rr_f;
            rearm                             <= 1'b0;
            cfg_interrupt_msi_int             <= 32'h1 << f_idx[rr_f];
            cfg_interrupt_msi_function_number <= {2'b00, rr_f};
            state                             <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (cfg_interrupt_msi_fail) begin
            stat_fail <= 1'b1;
            cnt       <= 8'(RETRY_DELAY);
            state     <= ST_BACKOFF;
          end else if (cfg_interrupt_msi_sent) begin
            stat_sent <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_BACKOFF: begin
          cnt <= cnt - 8'd1;
          if (cnt <= 8'd1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep                                           <= '0;
      cfg_interrupt_msi_pending_status              <= '0;
      cfg_interrupt_msi_pending_status_data_enable  <= 1'b0;
      cfg_interrupt_msi_pending_status_function_num <= '0;
    end else begin
      cfg_interrupt_msi_pending_status_data_enable <= 1'b0;
      if (rep_vld) begin
        rep[rep_f]                                    <= pend[rep_f];
        cfg_interrupt_msi_pending_status              <= 32'(pend[rep_f]);
        cfg_interrupt_msi_pending_status_data_enable  <= 1'b1;
        cfg_interrupt_msi_pending_status_function_num <= {2'b00, rep_f};
      end
    end
  end

  assign cfg_interrupt_msi_attr        = '0;
  assign cfg_interrupt_msi_tph_present = 1'b0;
  assign cfg_interrupt_msi_tph_type    = '0;
  assign cfg_interrupt_msi_tph_st_tag  = '0;

endmodule

// File: tb/tb_pcie_us_msi_mf.sv
// Directed bench for pcie_us_msi_mf with a simple IP-side mask/response model.
module tb_pcie_us_msi_mf;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] msi_irq;
  logic [3:0]   en;
  logic [11:0]  mme;
  logic         mask_update;
  logic [31:0]  msi_data;
  logic [3:0]   sel;
  logic [31:0]  int_o;
  logic [3:0]   fn;
  logic         sent, fail;
  logic [31:0]  ps;
  logic         ps_de;
  logic [3:0]   ps_fn;
  logic [2:0]   attr;
  logic         tph_p;
  logic [1:0]   tph_t;
  logic [8:0]   tph_tag;
  logic         st_sent, st_fail, st_drop;

  logic [31:0]  tb_mask [4];
  int           n_vec = 0;
  int           n_err = 0;
  int           w;
  logic         seen;

  always #5 clk = ~clk;
  assign msi_data = tb_mask[sel[1:0]];

  pcie_us_msi_mf dut (
    .clk                                           (clk),
    .rst                                           (rst),
    .msi_irq                                       (msi_irq),
    .cfg_interrupt_msi_enable                      (en),
    .cfg_interrupt_msi_mmenable                    (mme),
    .cfg_interrupt_msi_mask_update                 (mask_update),
    .cfg_interrupt_msi_data                        (msi_data),
    .cfg_interrupt_msi_select                      (sel),
    .cfg_interrupt_msi_int                         (int_o),
    .cfg_interrupt_msi_function_number             (fn),
    .cfg_interrupt_msi_sent                        (sent),
    .cfg_interrupt_msi_fail                        (fail),
    .cfg_interrupt_msi_pending_status              (ps),
    .cfg_interrupt_msi_pending_status_data_enable  (ps_de),
    .cfg_interrupt_msi_pending_status_function_num (ps_fn),
    .cfg_interrupt_msi_attr                        (attr),
    .cfg_interrupt_msi_tph_present                 (tph_p),
    .cfg_interrupt_msi_tph_type                    (tph_t),
    .cfg_interrupt_msi_tph_st_tag                  (tph_tag),
    .stat_sent                                     (st_sent),
    .stat_fail                                     (st_fail),
    .stat_drop                                     (st_drop)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pulse_irq(input logic [127:0] bits);
    @(negedge clk) msi_irq = bits;
    @(negedge clk) msi_irq = '0;
  endtask

  task automatic pulse_upd();
    @(negedge clk) mask_update = 1'b1;
    @(negedge clk) mask_update = 1'b0;
  endtask

  task automatic expect_int(input string tag, input logic [31:0] exp_int,
                            input logic [3:0] exp_fn, output int waited);
    logic got;
    got    = 1'b0;
    waited = 0;
    while (!got && waited < 60) begin
      @(negedge clk);
      waited++;
      got = (int_o != 0);
    end
    chk({tag, "_seen"}, {31'd0, got}, 32'd1);
    chk({tag, "_int"}, int_o, exp_int);
    chk({tag, "_fn"}, {28'd0, fn}, {28'd0, exp_fn});
  endtask

  task automatic respond(input string tag, input logic s, input logic f);
    @(negedge clk) begin sent = s; fail = f; end
    @(negedge clk) begin sent = 1'b0; fail = 1'b0; end
    chk({tag, "_stat_sent"}, {31'd0, st_sent}, {31'd0, s & ~f});
    chk({tag, "_stat_fail"}, {31'd0, st_fail}, {31'd0, f});
  endtask

  task automatic quiet(input string tag, input int cycles);
    logic any;
    any = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      any = any | (int_o != 0);
    end
    chk({tag, "_no_int"}, {31'd0, any}, 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    msi_irq     = '0;
    en          = 4'hF;
    mme         = {3'd5, 3'd5, 3'd2, 3'd5};
    mask_update = 1'b0;
    sent        = 1'b0;
    fail        = 1'b0;
    for (int i = 0; i < 4; i++) tb_mask[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_int", int_o, 32'd0);
    chk("rst_de", {31'd0, ps_de}, 32'd0);
    chk("rst_sel", {28'd0, sel}, 32'd0);
    chk("rst_drop", {31'd0, st_drop}, 32'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("init_sel", {28'd0, sel}, 32'd3);

    // f0 v3: exact N+2 latency, pending report, then clear report
    pulse_irq(128'h1 << 3);
    chk("t1_lat_early", int_o, 32'd0);
    @(negedge clk);
    chk("t1_int", int_o, 32'h8);
    chk("t1_fn", {28'd0, fn}, 32'd0);
    chk("t1_ps_de", {31'd0, ps_de}, 32'd1);
    chk("t1_ps", ps, 32'h8);
    respond("t1", 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_clr_de", {31'd0, ps_de}, 32'd1);
    chk("t1_clr_ps", ps, 32'd0);
    chk("t1_clr_fn", {28'd0, ps_fn}, 32'd0);

    // f1 has 4 vectors; v9 is unallocated
    pulse_irq(128'h1 << 41);
    chk("t2_drop", {31'd0, st_drop}, 32'd1);
    quiet("t2", 6);

    // f2 v0 masked, then unmasked
    tb_mask[2] = 32'h1;
    pulse_upd();
    repeat (12) @(negedge clk);
    pulse_irq(128'h1 << 64);
    quiet("t3_masked", 8);
    tb_mask[2] = 32'h0;
    pulse_upd();
    expect_int("t3", 32'h1, 4'd2, w);
    respond("t3", 1'b1, 1'b0);

    // f3 v0 rejected, retried after back-off
    pulse_irq(128'h1 << 96);
    expect_int("t4a", 32'h1, 4'd3, w);
    respond("t4a", 1'b0, 1'b1);
    expect_int("t4b", 32'h1, 4'd3, w);
    chk("t4_gap", w, 32'd17);
    respond("t4b", 1'b1, 1'b0);

    // simultaneous f0 v1, f1 v0, f3 v2
    pulse_irq((128'h1 << 1) | (128'h1 << 32) | (128'h1 << 98));
    expect_int("t5a", 32'h2, 4'd0, w);
    respond("t5a", 1'b1, 1'b0);
    expect_int("t5b", 32'h1, 4'd1, w);
    respond("t5b", 1'b1, 1'b0);
    expect_int("t5c", 32'h4, 4'd3, w);
    respond("t5c", 1'b1, 1'b0);

    // re-edge on f2 v5 during WAIT keeps it pending
    pulse_irq(128'h1 << 69);
    expect_int("t6a", 32'h20, 4'd2, w);
    @(negedge clk) msi_irq = 128'h1 << 69;
    @(negedge clk) begin msi_irq = '0; sent = 1'b1; end
    @(negedge clk) sent = 1'b0;
    chk("t6a_stat_sent", {31'd0, st_sent}, 32'd1);
    expect_int("t6b", 32'h20, 4'd2, w);
    respond("t6b", 1'b1, 1'b0);
    quiet("t6_done", 5);

    // round-robin after f2: f3 ahead of f1
    pulse_irq((128'h1 << 33) | (128'h1 << 97));
    expect_int("t7a", 32'h2, 4'd3, w);
    respond("t7a", 1'b1, 1'b0);
    expect_int("t7b", 32'h2, 4'd1, w);
    respond("t7b", 1'b1, 1'b0);

    // sent with fail counts as fail
    pulse_irq(128'h1 << 0);
    expect_int("t8a", 32'h1, 4'd0, w);
    respond("t8a", 1'b1, 1'b1);
    expect_int("t8b", 32'h1, 4'd0, w);
    respond("t8b", 1'b1, 1'b0);

    // disabled function holds pending
    en = 4'b1110;
    pulse_irq(128'h1 << 2);
    quiet("t9_dis", 6);
    en = 4'hF;
    expect_int("t9", 32'h4, 4'd0, w);
    respond("t9", 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
